// File: rtl/sum_accumulator_if.sv
// Handshake bundle between an upstream 4-bit adder, the sum accumulator and
// the downstream consumer of frame totals.
//   in_sum/in_valid/in_ready : upstream adder results (valid/ready handshake)
//   clear                    : synchronous frame abort
//   out_total/out_sat        : accumulated frame total and its saturation flag
//   out_valid/out_ready      : downstream result handshake
// master: the environment side (drives inputs, observes results)
// slave : the accumulator side
interface sum_accumulator_if #(
  parameter int unsigned ACC_W = 8
) ();
  logic [4:0]       in_sum;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [ACC_W-1:0] out_total;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_sum, in_valid, clear, out_ready,
    input  in_ready, out_total, out_sat, out_valid
  );

  modport slave (
    input  in_sum, in_valid, clear, out_ready,
    output in_ready, out_total, out_sat, out_valid
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates COUNT adder sums per frame into a saturating ACC_W-bit total,
// then holds the result until the downstream pops it.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sum_accumulator_if slave (in_sum/in_valid/in_ready, clear,
//           out_total/out_sat/out_valid/out_ready)
module sum_accumulator #(
  parameter int unsigned COUNT = 4,
  parameter int unsigned ACC_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  sum_accumulator_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(COUNT + 1);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic [ACC_W-1:0] acc_q, acc_d, acc_clamped;
  logic             sat_q, sat_d;
  logic [ACC_W:0]   sum_wide;
  logic             accept, pop;

  // One extra bit catches overflow; acc <= 2^ACC_W-1 and in_sum <= 31 so it
  // can never overflow twice.
  assign sum_wide    = {1'b0, acc_q} + {{(ACC_W - 4){1'b0}}, bus.in_sum};
  assign acc_clamped = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
  assign count_inc   = count_q + CNT_W'(1);

  assign accept = bus.in_valid && (state_q == StAccum);
  assign pop    = bus.out_ready && (state_q == StHold);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    sat_d   = sat_q;

    if (bus.clear) begin
      // Abort wins over accept and pop alike.
      state_d = StAccum;
      count_d = '0;
      acc_d   = '0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (accept) begin
            acc_d   = acc_clamped;
            sat_d   = sat_q | sum_wide[ACC_W];
            count_d = count_inc;
            if (count_inc == CNT_W'(COUNT)) begin
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (pop) begin
            state_d = StAccum;
            count_d = '0;
            acc_d   = '0;
            sat_d   = 1'b0;
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  // Outputs depend on state only, so out_ready never reaches in_ready.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_total = '0;
    bus.out_sat   = 1'b0;
    if (state_q == StHold) begin
      bus.out_valid = 1'b1;
      bus.out_total = acc_q;
      bus.out_sat   = sat_q;
    end else begin
      bus.in_ready = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
      count_q <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: one DUT at ACC_W=8 and one at ACC_W=6,
// both COUNT=4, sharing clock and reset.
module tb_sum_accumulator;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  sum_accumulator_if #(.ACC_W(8)) b8 ();
  sum_accumulator_if #(.ACC_W(6)) b6 ();

  sum_accumulator #(.COUNT(4), .ACC_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  sum_accumulator #(.COUNT(4), .ACC_W(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [4:0] v);
    b8.in_valid = 1'b1;
    b8.in_sum   = v;
    step();
    b8.in_valid = 1'b0;
  endtask

  task automatic send6(input logic [4:0] v);
    b6.in_valid = 1'b1;
    b6.in_sum   = v;
    step();
    b6.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    tests_run++;
    if ({b8.in_ready, b8.out_valid, b8.out_total, b8.out_sat} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state: got rdy=%b vld=%b tot=%0d sat=%b, want 1 0 0 0",
               b8.in_ready, b8.out_valid, b8.out_total, b8.out_sat);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    b8.out_ready = 1'b1;
    send8(5'd1);
    send8(5'd2);
    send8(5'd3);
    tests_run++;
    if ({b8.out_valid, b8.in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL basic_early: got vld=%b rdy=%b, want 0 1", b8.out_valid, b8.in_ready);
    end
    send8(5'd4);
    tests_run++;
    if ({b8.out_valid, b8.out_total, b8.out_sat, b8.in_ready} !== {1'b1, 8'd10, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_hold: got vld=%b tot=%0d sat=%b rdy=%b, want 1 10 0 0",
               b8.out_valid, b8.out_total, b8.out_sat, b8.in_ready);
    end
    step();
    tests_run++;
    if ({b8.out_valid, b8.in_ready, b8.out_total} !== {1'b0, 1'b1, 8'd0}) begin
      tests_failed++;
      $display("FAIL basic_pop: got vld=%b rdy=%b tot=%0d, want 0 1 0",
               b8.out_valid, b8.in_ready, b8.out_total);
    end
    // Out-of-range value 31 is still summed: 4*31 = 124.
    for (int i = 0; i < 4; i++) send8(5'd31);
    tests_run++;
    if ({b8.out_valid, b8.out_total, b8.out_sat} !== {1'b1, 8'd124, 1'b0}) begin
      tests_failed++;
      $display("FAIL max_input: got vld=%b tot=%0d sat=%b, want 1 124 0",
               b8.out_valid, b8.out_total, b8.out_sat);
    end
    step();
  endtask

  task automatic test_saturate();
    b6.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send6(5'd30);
    tests_run++;
    if ({b6.out_valid, b6.out_total, b6.out_sat} !== {1'b1, 6'd63, 1'b1}) begin
      tests_failed++;
      $display("FAIL sat_frame: got vld=%b tot=%0d sat=%b, want 1 63 1",
               b6.out_valid, b6.out_total, b6.out_sat);
    end
    step();
    send6(5'd0);
    send6(5'd0);
    send6(5'd0);
    send6(5'd1);
    tests_run++;
    if ({b6.out_valid, b6.out_total, b6.out_sat} !== {1'b1, 6'd1, 1'b0}) begin
      tests_failed++;
      $display("FAIL sat_cleared: got vld=%b tot=%0d sat=%b, want 1 1 0",
               b6.out_valid, b6.out_total, b6.out_sat);
    end
    step();
  endtask

  task automatic test_backpressure();
    b8.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send8(5'd5);
    // Upstream keeps offering data while blocked.
    b8.in_valid = 1'b1;
    b8.in_sum   = 5'd9;
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if ({b8.out_valid, b8.out_total, b8.in_ready} !== {1'b1, 8'd20, 1'b0}) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got vld=%b tot=%0d rdy=%b, want 1 20 0",
                 c, b8.out_valid, b8.out_total, b8.in_ready);
      end
      step();
    end
    b8.out_ready = 1'b1;
    step();
    b8.in_valid = 1'b0;
    tests_run++;
    if ({b8.out_valid, b8.in_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL bp_pop: got vld=%b rdy=%b, want 0 1", b8.out_valid, b8.in_ready);
    end
    for (int i = 0; i < 4; i++) send8(5'd1);
    tests_run++;
    if ({b8.out_valid, b8.out_total} !== {1'b1, 8'd4}) begin
      tests_failed++;
      $display("FAIL bp_next: got vld=%b tot=%0d, want 1 4", b8.out_valid, b8.out_total);
    end
    step();
  endtask

  task automatic test_clear();
    b8.out_ready = 1'b1;
    send8(5'd7);
    send8(5'd7);
    // Accept offered alongside clear must be discarded.
    b8.clear    = 1'b1;
    b8.in_valid = 1'b1;
    b8.in_sum   = 5'd7;
    step();
    b8.clear    = 1'b0;
    b8.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) send8(5'd1);
    tests_run++;
    if ({b8.out_valid, b8.out_total} !== {1'b1, 8'd4}) begin
      tests_failed++;
      $display("FAIL clear_accum: got vld=%b tot=%0d, want 1 4", b8.out_valid, b8.out_total);
    end
    b8.clear = 1'b1;
    step();
    b8.clear = 1'b0;
    tests_run++;
    if ({b8.out_valid, b8.in_ready, b8.out_total} !== {1'b0, 1'b1, 8'd0}) begin
      tests_failed++;
      $display("FAIL clear_pop: got vld=%b rdy=%b tot=%0d, want 0 1 0",
               b8.out_valid, b8.in_ready, b8.out_total);
    end
    for (int i = 0; i < 4; i++) send8(5'd3);
    tests_run++;
    if ({b8.out_valid, b8.out_total} !== {1'b1, 8'd12}) begin
      tests_failed++;
      $display("FAIL clear_next: got vld=%b tot=%0d, want 1 12", b8.out_valid, b8.out_total);
    end
    step();
  endtask

  task automatic test_async_reset();
    b8.out_ready = 1'b0;
    send8(5'd3);
    send8(5'd3);
    send8(5'd3);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({b8.in_ready, b8.out_valid, b8.out_total, b8.out_sat} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL arst_mid: got rdy=%b vld=%b tot=%0d sat=%b, want 1 0 0 0",
               b8.in_ready, b8.out_valid, b8.out_total, b8.out_sat);
    end
    step();
    #2 rst_n = 1'b1;
    // Frame into HOLD, then reset between edges must drop the pending result.
    for (int i = 0; i < 4; i++) send8(5'd6);
    tests_run++;
    if ({b8.out_valid, b8.out_total} !== {1'b1, 8'd24}) begin
      tests_failed++;
      $display("FAIL arst_prehold: got vld=%b tot=%0d, want 1 24", b8.out_valid, b8.out_total);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({b8.in_ready, b8.out_valid, b8.out_total} !== {1'b1, 1'b0, 8'd0}) begin
      tests_failed++;
      $display("FAIL arst_hold: got rdy=%b vld=%b tot=%0d, want 1 0 0",
               b8.in_ready, b8.out_valid, b8.out_total);
    end
    step();
    #2 rst_n = 1'b1;
    b8.out_ready = 1'b1;
    // First edge after release must already accept.
    for (int i = 0; i < 4; i++) send8(5'd2);
    tests_run++;
    if ({b8.out_valid, b8.out_total, b8.out_sat} !== {1'b1, 8'd8, 1'b0}) begin
      tests_failed++;
      $display("FAIL arst_after: got vld=%b tot=%0d sat=%b, want 1 8 0",
               b8.out_valid, b8.out_total, b8.out_sat);
    end
    step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    b8.in_sum    = '0;
    b8.in_valid  = 1'b0;
    b8.clear     = 1'b0;
    b8.out_ready = 1'b0;
    b6.in_sum    = '0;
    b6.in_valid  = 1'b0;
    b6.clear     = 1'b0;
    b6.out_ready = 1'b0;

    test_reset();
    test_basic();
    test_saturate();
    test_backpressure();
    test_clear();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
